mem_dp48: RTL and testbench

MEM_DP48 -- requirements
Module: mem_dp48

---
 rtl/mem_dp48.sv | 116 +++++++++++
 tb/tb_mem_dp48.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dp48.sv
// Dual-port 24-bit word memory with 24/48-bit accesses, registered addresses,
// and a sequential zero-fill that runs after reset or on request.
module mem_dp48 #(
    parameter int DEPTH_LOG2     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        iw_clk,
    input  logic        iw_rst,
    input  logic [47:0] iw_mem_addr  [0:1],
    input  logic        iw_mem_we    [0:1],
    input  logic [47:0] iw_mem_wdata [0:1],
    input  logic        iw_mem_is48  [0:1],
    input  logic        iw_clear,
    output logic [47:0] ow_mem_rdata [0:1],
    output logic        ow_mem_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] ONE = 1;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    logic [DEPTH_LOG2-1:0]   r_cnt;
    logic [47:0]             r_addr [0:1];
    logic [23:0]             mem    [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0]   idx_lo [0:1];
    logic [DEPTH_LOG2-1:0]   idx_hi [0:1];
    logic                    unused_addr_hi;

    assign unused_addr_hi = ^{r_addr[0][47:DEPTH_LOG2],
                              r_addr[1][47:DEPTH_LOG2]};

    // Upper word index wraps naturally in the narrow index width.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx_lo[p] = r_addr[p][DEPTH_LOG2-1:0];
            idx_hi[p] = idx_lo[p] + ONE;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_addr[0] <= '0;
            r_addr[1] <= '0;
        end else begin
            r_addr[0] <= iw_mem_addr[0];
            r_addr[1] <= iw_mem_addr[1];
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_cnt        <= '0;
            state        <= CLEAR_ON_RESET ? CLEAR : READY;
            ow_mem_ready <= !CLEAR_ON_RESET;
        end else begin
            case (state)
                CLEAR: begin
                    if (iw_clear) begin
                        r_cnt <= '0;
                    end else if (r_cnt == '1) begin
                        r_cnt        <= '0;
                        state        <= READY;
                        ow_mem_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                READY: begin
                    if (iw_clear) begin
                        r_cnt        <= '0;
                        state        <= CLEAR;
                        ow_mem_ready <= 1'b0;
                    end
                end
                default: begin
                    r_cnt        <= '0;
                    state        <= CLEAR;
                    ow_mem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is applied last so it wins any overlapping word.
    always_ff @(posedge iw_clk) begin
        if (state == CLEAR) begin
            mem[r_cnt] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (iw_mem_we[p]) begin
                    mem[idx_lo[p]] <= iw_mem_wdata[p][23:0];
                    if (iw_mem_is48[p])
                        mem[idx_hi[p]] <= iw_mem_wdata[p][47:24];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ow_mem_rdata[p] = '0;
            if (state == READY) begin
                if (iw_mem_is48[p])
                    ow_mem_rdata[p] = {mem[idx_hi[p]], mem[idx_lo[p]]};
                else
                    ow_mem_rdata[p] = {24'b0, mem[idx_lo[p]]};
            end
        end
    end

endmodule

// File: tb/tb_mem_dp48.sv
// Directed bench for mem_dp48: zero-fill timing, 24/48-bit access,
// wrap, port collision, clear and reset-during-clear behaviour.
module tb_mem_dp48;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [47:0] a0 [0:1];
    logic        we0 [0:1];
    logic [47:0] wd0 [0:1];
    logic        s0 [0:1];
    logic [47:0] rd0 [0:1];
    logic        clr0, rdy0;
    logic [47:0] a1 [0:1];
    logic        we1 [0:1];
    logic [47:0] wd1 [0:1];
    logic        s1 [0:1];
    logic [47:0] rd1 [0:1];
    logic        clr1, rdy1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_dp48 #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut0 (
        .iw_clk(clk), .iw_rst(rst0),
        .iw_mem_addr(a0), .iw_mem_we(we0),
        .iw_mem_wdata(wd0), .iw_mem_is48(s0),
        .iw_clear(clr0),
        .ow_mem_rdata(rd0), .ow_mem_ready(rdy0)
    );

    mem_dp48 #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b0)) dut1 (
        .iw_clk(clk), .iw_rst(rst1),
        .iw_mem_addr(a1), .iw_mem_we(we1),
        .iw_mem_wdata(wd1), .iw_mem_is48(s1),
        .iw_clear(clr1),
        .ow_mem_rdata(rd1), .ow_mem_ready(rdy1)
    );

    // Address phase, then data phase; rd is sampled before the write edge.
    task automatic do_op(input int p, input logic [47:0] a,
                         input logic w, input logic [47:0] d,
                         input logic wide, output logic [47:0] rd);
        @(negedge clk);
        a0[p] = a;
        we0[p] = 1'b0;
        @(negedge clk);
        we0[p] = w;
        wd0[p] = d;
        s0[p] = wide;
        #1 rd = rd0[p];
        @(negedge clk);
        we0[p] = 1'b0;
        s0[p] = 1'b0;
    endtask

    task automatic count_ready(input string name, input int exp);
        int cnt = 0;
        while (!rdy0 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        nvec++;
        if (cnt !== exp) begin
            nerr++;
            $display("FAIL %s: ready low %0d cycles, expected %0d",
                     name, cnt, exp);
        end
    endtask

    task automatic test_reset;
        logic [47:0] rd;
        repeat (2) @(negedge clk);
        nvec++;
        if (rdy0 !== 1'b0 || rd0[0] !== 48'h0 || rd0[1] !== 48'h0) begin
            nerr++;
            $display("FAIL reset_state: ready=%b rd0=%h rd1=%h, expected 0",
                     rdy0, rd0[0], rd0[1]);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        count_ready("reset_fill", 16);
        for (int i = 0; i < 16; i++) begin
            do_op(0, 48'(i), 1'b0, 48'h0, 1'b0, rd);
            nvec++;
            if (rd !== 48'h0) begin
                nerr++;
                $display("FAIL zero_word[%0d]: got %h, expected 0", i, rd);
            end
        end
    endtask

    task automatic test_word24;
        logic [47:0] rd;
        do_op(0, 48'd3, 1'b1, 48'h000000ABCDEF, 1'b0, rd);
        do_op(1, 48'd3, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000ABCDEF) begin
            nerr++;
            $display("FAIL rd24_addr3: got %h, expected 000000abcdef", rd);
        end
        do_op(1, 48'd3, 1'b0, 48'h0, 1'b1, rd);
        nvec++;
        if (rd !== 48'h000000ABCDEF) begin
            nerr++;
            $display("FAIL rd48_addr3: got %h, expected 000000abcdef", rd);
        end
        // Upper address bits must be ignored.
        do_op(0, 48'hF00000000013, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000ABCDEF) begin
            nerr++;
            $display("FAIL addr_hi_ignored: got %h, expected 000000abcdef", rd);
        end
    endtask

    task automatic test_wrap48;
        logic [47:0] rd;
        do_op(1, 48'd15, 1'b1, 48'h112233445566, 1'b1, rd);
        do_op(0, 48'd15, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000445566) begin
            nerr++;
            $display("FAIL wrap_lo: got %h, expected 000000445566", rd);
        end
        do_op(0, 48'd0, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000112233) begin
            nerr++;
            $display("FAIL wrap_hi: got %h, expected 000000112233", rd);
        end
        do_op(1, 48'd15, 1'b0, 48'h0, 1'b1, rd);
        nvec++;
        if (rd !== 48'h112233445566) begin
            nerr++;
            $display("FAIL wrap_rd48: got %h, expected 112233445566", rd);
        end
    endtask

    task automatic test_rdw;
        logic [47:0] rd;
        do_op(0, 48'd3, 1'b1, 48'h000000123456, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000ABCDEF) begin
            nerr++;
            $display("FAIL rdw_old: got %h, expected 000000abcdef", rd);
        end
        do_op(1, 48'd3, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000123456) begin
            nerr++;
            $display("FAIL rdw_new: got %h, expected 000000123456", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] rd;
        @(negedge clk);
        a0[0] = 48'd5;
        a0[1] = 48'd5;
        @(negedge clk);
        we0[0] = 1'b1; wd0[0] = 48'h000001;
        we0[1] = 1'b1; wd0[1] = 48'h000002;
        #1 rd = rd0[0];
        nvec++;
        if (rd !== 48'h0) begin
            nerr++;
            $display("FAIL collide_old: got %h, expected 0", rd);
        end
        @(negedge clk);
        we0[0] = 1'b0;
        we0[1] = 1'b0;
        do_op(0, 48'd5, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h000000000002) begin
            nerr++;
            $display("FAIL collide_p1_wins: got %h, expected 2", rd);
        end
        // 48-bit port 0 pair overlapping a 24-bit port 1 write at word 7.
        @(negedge clk);
        a0[0] = 48'd6;
        a0[1] = 48'd7;
        @(negedge clk);
        we0[0] = 1'b1; s0[0] = 1'b1; wd0[0] = 48'hAAAAAABBBBBB;
        we0[1] = 1'b1; s0[1] = 1'b0; wd0[1] = 48'h000000CCCCCC;
        @(negedge clk);
        we0[0] = 1'b0; s0[0] = 1'b0;
        we0[1] = 1'b0;
        do_op(1, 48'd6, 1'b0, 48'h0, 1'b1, rd);
        nvec++;
        if (rd !== 48'hCCCCCCBBBBBB) begin
            nerr++;
            $display("FAIL overlap_pair: got %h, expected ccccccbbbbbb", rd);
        end
    endtask

    task automatic test_clear;
        logic [47:0] rd;
        int cnt = 0;
        int bad = 0;
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        a0[0] = 48'd9;
        we0[0] = 1'b1;
        wd0[0] = 48'h777777;
        while (!rdy0 && cnt < 100) begin
            cnt++;
            if (rd0[0] !== 48'h0 || rd0[1] !== 48'h0) bad++;
            if (cnt == 8) we0[0] = 1'b0;
            @(negedge clk);
        end
        we0[0] = 1'b0;
        nvec++;
        if (cnt !== 16) begin
            nerr++;
            $display("FAIL clear_len: ready low %0d cycles, expected 16", cnt);
        end
        nvec++;
        if (bad !== 0) begin
            nerr++;
            $display("FAIL clear_rdata: %0d nonzero reads, expected 0", bad);
        end
        for (int i = 0; i < 16; i++) begin
            do_op(i % 2, 48'(i), 1'b0, 48'h0, 1'b0, rd);
            nvec++;
            if (rd !== 48'h0) begin
                nerr++;
                $display("FAIL cleared_word[%0d]: got %h, expected 0", i, rd);
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [47:0] rd;
        do_op(0, 48'd2, 1'b1, 48'h000000654321, 1'b0, rd);
        @(negedge clk);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        repeat (6) @(negedge clk);
        rst0 = 1'b1;
        #1;
        nvec++;
        if (rdy0 !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_ready: got %b, expected 0", rdy0);
        end
        @(negedge clk);
        rst0 = 1'b0;
        count_ready("rst_mid_fill", 16);
        do_op(0, 48'd2, 1'b0, 48'h0, 1'b0, rd);
        nvec++;
        if (rd !== 48'h0) begin
            nerr++;
            $display("FAIL rst_mid_word2: got %h, expected 0", rd);
        end
    endtask

    task automatic test_preserve;
        nvec++;
        if (rdy1 !== 1'b1) begin
            nerr++;
            $display("FAIL nclr_ready: got %b, expected 1", rdy1);
        end
        @(negedge clk);
        a1[0] = 48'd2;
        @(negedge clk);
        we1[0] = 1'b1;
        wd1[0] = 48'h5A5A5A;
        @(negedge clk);
        we1[0] = 1'b0;
        rst1 = 1'b1;
        #1;
        nvec++;
        if (rdy1 !== 1'b1) begin
            nerr++;
            $display("FAIL nclr_rst_ready: got %b, expected 1", rdy1);
        end
        @(negedge clk);
        rst1 = 1'b0;
        a1[0] = 48'd2;
        @(negedge clk);
        #1;
        nvec++;
        if (rd1[0] !== 48'h00000005A5A5A) begin
            nerr++;
            $display("FAIL nclr_preserve: got %h, expected 5a5a5a", rd1[0]);
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        clr0 = 1'b0;
        clr1 = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a0[p] = '0; we0[p] = 1'b0; wd0[p] = '0; s0[p] = 1'b0;
            a1[p] = '0; we1[p] = 1'b0; wd1[p] = '0; s1[p] = 1'b0;
        end
        test_reset;
        test_preserve;
        test_word24;
        test_wrap48;
        test_rdw;
        test_back_to_back;
        test_clear;
        test_reset_mid_clear;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
